// File: rtl/debounce_input.sv
// Single-bit debouncer: two-flop synchronizer, consecutive-sample qualification
// window, and registered one-clock rise/fall strobes of the debounced level.
`timescale 1ns/100ps
module debounce_input #(
  parameter int unsigned DEBOUNCE_LIMIT = 10
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Signal,
  output logic o_DebouncedSignal,
  output logic o_Rise,
  output logic o_Fall
);
  localparam int unsigned CW = $clog2(DEBOUNCE_LIMIT) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);

  logic          sync1_q, sync2_q, state_q, rise_q, fall_q;
  logic          sync1_d, sync2_d, state_d, rise_d, fall_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    sync1_d = i_Signal;
    sync2_d = sync1_q;
    state_d = state_q;
    count_d = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    // Any cycle agreeing with the current state restarts the window from zero
    if (sync2_q != state_q) begin
      if (count_q < LAST) begin
        count_d = count_q + CW'(1);
      end else begin
        state_d = sync2_q;
        rise_d  = sync2_q;
        fall_d  = ~sync2_q;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      count_q <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      count_q <= count_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_DebouncedSignal = state_q;
  assign o_Rise            = rise_q;
  assign o_Fall            = fall_q;

endmodule

// File: tb/tb_debounce_input.sv
// Bench for debounce_input: LIMIT=10 and LIMIT=1 instances, expected strobes
// queued at stimulus time with the edge index they must appear on.
`timescale 1ns/100ps
module tb_debounce_input;
  typedef struct {
    int unsigned edge_n;
    logic        rise;
  } ev_t;

  logic clk   = 1'b1;
  logic rst_n = 1'b0;
  logic sig   = 1'b1;
  logic sig1  = 1'b1;
  logic deb, rise, fall, deb1, rise1, fall1;

  int unsigned ecount = 0;
  int          total  = 0;
  int          bad    = 0;
  ev_t         q10[$];
  ev_t         q1[$];
  ev_t         em10, em1;

  debounce_input #(.DEBOUNCE_LIMIT(10)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Signal(sig),
    .o_DebouncedSignal(deb), .o_Rise(rise), .o_Fall(fall)
  );

  debounce_input #(.DEBOUNCE_LIMIT(1)) dut1 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Signal(sig1),
    .o_DebouncedSignal(deb1), .o_Rise(rise1), .o_Fall(fall1)
  );

  initial forever #2 clk = ~clk;

  initial forever begin
    @(posedge clk);
    ecount = ecount + 1;
  end

  // Scoreboard: every strobe seen must match the head of its queue
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (rise || fall) begin
        total++;
        if (q10.size() == 0) begin
          bad++;
          $display("FAIL strobe10_unexpected: edge=%0d rise=%b fall=%b, required no strobe", ecount, rise, fall);
        end else begin
          em10 = q10.pop_front();
          if (em10.edge_n !== ecount || rise !== em10.rise || fall !== !em10.rise || deb !== em10.rise) begin
            bad++;
            $display("FAIL strobe10: edge=%0d rise=%b fall=%b deb=%b, required edge=%0d rise=%b fall=%b deb=%b",
                     ecount, rise, fall, deb, em10.edge_n, em10.rise, !em10.rise, em10.rise);
          end
        end
      end
      if (rise1 || fall1) begin
        total++;
        if (q1.size() == 0) begin
          bad++;
          $display("FAIL strobe1_unexpected: edge=%0d rise=%b fall=%b, required no strobe", ecount, rise1, fall1);
        end else begin
          em1 = q1.pop_front();
          if (em1.edge_n !== ecount || rise1 !== em1.rise || fall1 !== !em1.rise || deb1 !== em1.rise) begin
            bad++;
            $display("FAIL strobe1: edge=%0d rise=%b fall=%b deb=%b, required edge=%0d rise=%b fall=%b deb=%b",
                     ecount, rise1, fall1, deb1, em1.edge_n, em1.rise, !em1.rise, em1.rise);
          end
        end
      end
    end
  end

  task automatic test_reset();
    #1;
    total++;
    if ({deb, rise, fall, deb1, rise1, fall1} !== 6'b0) begin
      bad++;
      $display("FAIL reset_t1: outs=%b, required 000000", {deb, rise, fall, deb1, rise1, fall1});
    end
    @(posedge clk); #1;
    total++;
    if ({deb, rise, fall, deb1, rise1, fall1} !== 6'b0 || dut.count_q !== 0) begin
      bad++;
      $display("FAIL reset_edge: outs=%b count=%0d, required 000000 count=0",
               {deb, rise, fall, deb1, rise1, fall1}, dut.count_q);
    end
    sig  = 1'b0;
    sig1 = 1'b0;
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    total++;
    if ({deb, rise, fall, deb1, rise1, fall1} !== 6'b0) begin
      bad++;
      $display("FAIL reset_release: outs=%b, required 000000", {deb, rise, fall, deb1, rise1, fall1});
    end
  endtask

  task automatic test_bounce();
    @(posedge clk); #2;
    sig = 1'b1; #9;
    sig = 1'b0; #2;
    sig = 1'b1; #9;
    sig = 1'b0; #9;
    repeat (16) @(posedge clk); #1;
    total++;
    if (deb !== 1'b0 || dut.count_q !== 0) begin
      bad++;
      $display("FAIL bounce: deb=%b count=%0d, required deb=0 count=0", deb, dut.count_q);
    end
  endtask

  task automatic test_clean_press();
    @(posedge clk); #1;
    sig = 1'b1;
    q10.push_back('{ecount + 12, 1'b1});
    repeat (11) @(posedge clk); #1;
    total++;
    if (deb !== 1'b0) begin
      bad++;
      $display("FAIL press_early: deb=%b at edge 11, required 0", deb);
    end
    @(posedge clk); #1;
    total++;
    if (deb !== 1'b1 || rise !== 1'b1 || fall !== 1'b0) begin
      bad++;
      $display("FAIL press_edge12: deb=%b rise=%b fall=%b, required 1 1 0", deb, rise, fall);
    end
    @(posedge clk); #1;
    total++;
    if (deb !== 1'b1 || rise !== 1'b0) begin
      bad++;
      $display("FAIL press_width: deb=%b rise=%b, required 1 0", deb, rise);
    end
    repeat (40) @(posedge clk); #1;
    total++;
    if (deb !== 1'b1 || q10.size() !== 0) begin
      bad++;
      $display("FAIL press_hold: deb=%b pending=%0d, required deb=1 pending=0", deb, q10.size());
    end
  endtask

  task automatic test_bouncy_release();
    @(posedge clk); #0.5;
    sig = 1'b0; #9;
    sig = 1'b1; #9;
    sig = 1'b0; #9;
    sig = 1'b1; #2;
    sig = 1'b0;
    q10.push_back('{ecount + 12, 1'b0});
    total++;
    if (deb !== 1'b1) begin
      bad++;
      $display("FAIL release_bounces: deb=%b, required 1", deb);
    end
    repeat (11) @(posedge clk); #1;
    total++;
    if (deb !== 1'b1) begin
      bad++;
      $display("FAIL release_early: deb=%b at edge 11, required 1", deb);
    end
    @(posedge clk); #1;
    total++;
    if (deb !== 1'b0 || fall !== 1'b1 || rise !== 1'b0) begin
      bad++;
      $display("FAIL release_edge12: deb=%b rise=%b fall=%b, required 0 0 1", deb, rise, fall);
    end
    @(posedge clk); #1;
    total++;
    if (fall !== 1'b0 || dut.count_q !== 0) begin
      bad++;
      $display("FAIL release_width: fall=%b count=%0d, required 0 0", fall, dut.count_q);
    end
  endtask

  task automatic test_boundary();
    @(posedge clk); #1;
    sig = 1'b1;
    repeat (9) @(posedge clk); #1;
    sig = 1'b0;
    repeat (2) @(posedge clk); #1;
    total++;
    if (dut.count_q !== 9 || deb !== 1'b0) begin
      bad++;
      $display("FAIL boundary9_peak: count=%0d deb=%b, required 9 0", dut.count_q, deb);
    end
    repeat (4) @(posedge clk); #1;
    total++;
    if (dut.count_q !== 0 || deb !== 1'b0) begin
      bad++;
      $display("FAIL boundary9_after: count=%0d deb=%b, required 0 0", dut.count_q, deb);
    end
    @(posedge clk); #1;
    sig = 1'b1;
    q10.push_back('{ecount + 12, 1'b1});
    repeat (10) @(posedge clk); #1;
    sig = 1'b0;
    q10.push_back('{ecount + 12, 1'b0});
    repeat (2) @(posedge clk); #1;
    total++;
    if (deb !== 1'b1 || dut.count_q !== 0) begin
      bad++;
      $display("FAIL boundary10_flip: deb=%b count=%0d, required 1 0", deb, dut.count_q);
    end
    repeat (12) @(posedge clk); #1;
    total++;
    if (deb !== 1'b0 || dut.count_q !== 0 || q10.size() !== 0) begin
      bad++;
      $display("FAIL boundary10_back: deb=%b count=%0d pending=%0d, required 0 0 0", deb, dut.count_q, q10.size());
    end
  endtask

  task automatic test_reset_midcount();
    @(posedge clk); #1;
    sig = 1'b1;
    q10.push_back('{ecount + 12, 1'b1});
    repeat (14) @(posedge clk); #1;
    total++;
    if (deb !== 1'b1) begin
      bad++;
      $display("FAIL midrst_setup: deb=%b, required 1", deb);
    end
    @(posedge clk); #1;
    sig = 1'b0;
    repeat (6) @(posedge clk); #1;
    total++;
    if (dut.count_q !== 4) begin
      bad++;
      $display("FAIL midrst_counting: count=%0d, required 4", dut.count_q);
    end
    rst_n = 1'b0;
    #0.5;
    total++;
    if (deb !== 1'b0 || rise !== 1'b0 || fall !== 1'b0 || dut.count_q !== 0) begin
      bad++;
      $display("FAIL midrst_async: deb=%b rise=%b fall=%b count=%0d, required 0 0 0 0", deb, rise, fall, dut.count_q);
    end
    sig = 1'b1;
    @(posedge clk); #1;
    #1 rst_n = 1'b1;
    q10.push_back('{ecount + 12, 1'b1});
    repeat (11) @(posedge clk); #1;
    total++;
    if (deb !== 1'b0) begin
      bad++;
      $display("FAIL midrst_requal_early: deb=%b at edge 11, required 0", deb);
    end
    @(posedge clk); #1;
    total++;
    if (deb !== 1'b1 || rise !== 1'b1) begin
      bad++;
      $display("FAIL midrst_requal: deb=%b rise=%b, required 1 1", deb, rise);
    end
  endtask

  task automatic test_limit1();
    int holds[8] = '{3, 1, 2, 1, 4, 1, 1, 5};
    foreach (holds[i]) begin
      @(posedge clk); #1;
      sig1 = ~sig1;
      q1.push_back('{ecount + 3, sig1});
      total++;
      if (dut1.count_q !== 0) begin
        bad++;
        $display("FAIL limit1_count: count=%0d step=%0d, required 0", dut1.count_q, i);
      end
      repeat (holds[i] - 1) @(posedge clk);
    end
    repeat (6) @(posedge clk); #1;
    total++;
    if (deb1 !== sig1 || q1.size() !== 0) begin
      bad++;
      $display("FAIL limit1_final: deb=%b pending=%0d, required deb=%b pending=0", deb1, q1.size(), sig1);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_clean_press();
    test_bouncy_release();
    test_boundary();
    test_reset_midcount();
    test_limit1();
    repeat (4) @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run still active at 100000 ns, required finish");
    $fatal(1);
  end

endmodule

// File: doc/debounce_input.md
# debounce_input

Single-bit debouncer for mechanical switch or button inputs. It synchronizes an asynchronous input into the `i_Clk` domain. The clean output changes state only after the synchronized input has held a new level for `DEBOUNCE_LIMIT` consecutive clocks. It sits between a board pin and downstream control logic, and also provides one-cycle edge strobes of the debounced level.

## Interface
- `DEBOUNCE_LIMIT`, default 10: number of consecutive clocks the synchronized input must differ from the current output before the output flips. Legal range is 1 to 2^20.
- `i_Clk` in 1: system clock. All logic is on the rising edge.
- `i_Rst_n` in 1: reset, asynchronous and active-low. Assertion immediately clears all state; deassertion is synchronous to `i_Clk` by system convention.
- `i_Signal` in 1: raw, bouncy, asynchronous input.
- `o_DebouncedSignal` out 1: debounced level, registered.
- `o_Rise` out 1: one-clock pulse when `o_DebouncedSignal` goes 0→1.
- `o_Fall` out 1: one-clock pulse when `o_DebouncedSignal` goes 1→0.

## Operation
- **Synchronizer:** two flops in series, `sync1 <= i_Signal` and `sync2 <= sync1`. Only `sync2` feeds the debounce logic.
- **State register:** `r_State` drives `o_DebouncedSignal` directly.
- **Counter:** `r_Count`, width `$clog2(DEBOUNCE_LIMIT)+1`, unsigned, never wraps.
- **Per-clock rules, in priority order:**
  - If `sync2 != r_State` and `r_Count < DEBOUNCE_LIMIT-1`: `r_Count <= r_Count+1`.
  - Else if `sync2 != r_State` and `r_Count == DEBOUNCE_LIMIT-1`: `r_State <= sync2` and `r_Count <= 0`.
  - Else (`sync2 == r_State`): `r_Count <= 0`.
- **Bounce rejection:** any single cycle in which `sync2` matches `r_State` restarts the qualification window from zero.
- **Edge strobes:**
  - `o_Rise <= (state flips this cycle) && sync2==1`.
  - `o_Fall <= (state flips this cycle) && sync2==0`.
  - Both strobes are registered, so they are high during the same cycle in which `o_DebouncedSignal` first shows the new level.
  - `o_Rise` and `o_Fall` are never high together.
- **`DEBOUNCE_LIMIT == 1`:** the output follows `sync2` with one extra clock of delay, and the counter stays at 0.
- **Reset (`i_Rst_n` low):** `sync1`, `sync2`, `r_State`, `r_Count`, `o_Rise` and `o_Fall` all go to 0 asynchronously. `o_DebouncedSignal` therefore resets to 0.
- **Reset mid-qualification:** any count in progress is discarded. After release, qualification starts from count 0 against state 0.

## Timing
- **Latency:** when `i_Signal` changes and then holds, `o_DebouncedSignal` changes on rising edge number `DEBOUNCE_LIMIT+2` after the first edge that samples the new level. That is 2 edges for the synchronizer plus `DEBOUNCE_LIMIT` qualifying edges.
  - Default `DEBOUNCE_LIMIT=10` with a 4 ns clock: 12 edges, 48 ns.
- **Minimum accepted pulse:** `i_Signal` must be sampled at the new level on `DEBOUNCE_LIMIT` consecutive edges. Shorter glitches produce no output change and no strobe.
- **Strobe width:** `o_Rise`/`o_Fall` are exactly 1 clock wide. They are asserted in the cycle after the flip decision, which is the same cycle `o_DebouncedSignal` updates.
- **Output stability:** outputs are glitch-free flop outputs, with no combinational path from `i_Signal`.

## Test plan
Clock 4 ns period, `DEBOUNCE_LIMIT=10`, `i_Rst_n` released at 6 ns, `i_Signal=0` at reset.
- **Reset values:** hold `i_Rst_n` low with `i_Signal=1` → `o_DebouncedSignal=0`, `o_Rise=0`, `o_Fall=0` throughout. Pull `i_Rst_n` low again while counting → output returns to 0 immediately, without waiting for a clock edge.
- **Bounce rejection:** toggle `i_Signal` with high pulses of 9 ns, low gaps of 2 ns and 9 ns, for about 30 ns → `o_DebouncedSignal` stays 0 and `o_Rise` never asserts.
- **Clean press:** `i_Signal=1` held for 220 ns → `o_DebouncedSignal` rises exactly 12 edges after the first sampling edge, with `o_Rise` high for exactly 1 clock on that same edge. The output then stays 1 for the remainder of the hold.
- **Bouncy release:** while the output is 1, drive 9 ns low, 9 ns high, 9 ns low, 2 ns high, then hold 0 → output stays 1 during the bounces. It falls 12 edges after the final 0 is first sampled, with a single-clock `o_Fall`.
- **Boundary count:** `i_Signal` held at the new level for exactly 9 sampled edges and then restored → no output change. Held for exactly 10 sampled edges → output flips. Confirm the counter resets to 0 after each case.
- **LIMIT=1 instance:** output tracks `i_Signal` with a fixed 3-edge delay. Every level change produces exactly one `o_Rise` or `o_Fall` pulse.
